// File: rtl/debug_command_unit_if.sv
// ---------------------------------------------------------------------------
// debug_command_unit_if
//   Bundles the byte link and decoder-select signals between the debug
//   command unit and its surroundings.
//
//   rx_data  [7:0]  received command byte
//   rx_valid        one-cycle strobe qualifying rx_data
//   result   [31:0] decoder output, combinational in code
//   code     [7:0]  decoder select code
//   tx_data  [7:0]  byte toward the UART transmitter
//   tx_valid        tx_data valid, held until accepted
//   tx_ready        transmitter accepts on tx_valid & tx_ready
//
//   master: the command unit side.  slave: the UART / decoder side.
// ---------------------------------------------------------------------------
interface debug_command_unit_if;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [31:0] result;
    logic [7:0]  code;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;

    modport master (
        input  rx_data, rx_valid, result, tx_ready,
        output code, tx_data, tx_valid
    );

    modport slave (
        output rx_data, rx_valid, result, tx_ready,
        input  code, tx_data, tx_valid
    );
endinterface

// File: rtl/debug_command_unit.sv
// ---------------------------------------------------------------------------
// debug_command_unit
//   Interprets debug command bytes from the UART link, gates the pipeline
//   clock enable (step / run / halt), selects a decoder result, captures it
//   and streams it back as 4 bytes MSB first. Also counts executed pipeline
//   cycles and reports the count on request.
//
//   Commands (accepted in IDLE only):
//     0x01 single step, 0x02 run, 0x03 halt (no-op in IDLE),
//     0x04 report cycle count, 1xxx_xxxx read decoder result for that code.
//
//   Ports:
//     clk      system clock, rising edge
//     reset    asynchronous active-low reset
//     bus      debug_command_unit_if.master (rx / tx / decoder signals)
//     pipe_en  pipeline clock enable (registered)
//     halted   1 unless running or stepping (registered)
//     busy     1 in any state other than IDLE (registered)
// ---------------------------------------------------------------------------
module debug_command_unit #(
    parameter int CYCLE_W = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    debug_command_unit_if.master   bus,
    output logic                   pipe_en,
    output logic                   halted,
    output logic                   busy
);

    typedef enum logic [2:0] {
        IDLE,
        STEP,
        RUN,
        LATCH,
        SEND
    } state_t;

    state_t               state;
    logic [CYCLE_W-1:0]   cycle_cnt;
    logic [31:0]          cycle_ext;
    logic [31:0]          shift;
    logic [1:0]           byte_cnt;

    // Zero-extend without a replication that would be zero-width at CYCLE_W=32.
    always_comb begin
        cycle_ext                = '0;
        cycle_ext[CYCLE_W-1:0]   = cycle_cnt;
    end

    // The byte on the wire is always the top of the shift register, so it is
    // stable for as long as the transmitter stalls.
    assign bus.tx_data = shift[31:24];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            bus.code     <= 8'h00;
            pipe_en      <= 1'b0;
            halted       <= 1'b1;
            bus.tx_valid <= 1'b0;
            busy         <= 1'b0;
            cycle_cnt    <= '0;
            shift        <= 32'h0;
            byte_cnt     <= 2'd0;
        end else begin
            // Every edge seen with the enable high is an executed cycle,
            // including the edge on which a halt command arrives.
            if (pipe_en)
                cycle_cnt <= cycle_cnt + CYCLE_W'(1);

            case (state)
                IDLE: begin
                    if (bus.rx_valid) begin
                        if (bus.rx_data[7]) begin
                            bus.code <= bus.rx_data;
                            state    <= LATCH;
                            busy     <= 1'b1;
                        end else begin
                            case (bus.rx_data)
                                8'h01: begin
                                    state   <= STEP;
                                    pipe_en <= 1'b1;
                                    halted  <= 1'b0;
                                    busy    <= 1'b1;
                                end
                                8'h02: begin
                                    state   <= RUN;
                                    pipe_en <= 1'b1;
                                    halted  <= 1'b0;
                                    busy    <= 1'b1;
                                end
                                8'h04: begin
                                    shift        <= cycle_ext;
                                    byte_cnt     <= 2'd0;
                                    bus.tx_valid <= 1'b1;
                                    state        <= SEND;
                                    busy         <= 1'b1;
                                end
                                default: ;
                            endcase
                        end
                    end
                end

                STEP: begin
                    state   <= IDLE;
                    pipe_en <= 1'b0;
                    halted  <= 1'b1;
                    busy    <= 1'b0;
                end

                RUN: begin
                    if (bus.rx_valid && bus.rx_data == 8'h03) begin
                        state   <= IDLE;
                        pipe_en <= 1'b0;
                        halted  <= 1'b1;
                        busy    <= 1'b0;
                    end
                end

                // Decoder has had a full cycle to settle on the new code.
                LATCH: begin
                    shift        <= bus.result;
                    byte_cnt     <= 2'd0;
                    bus.tx_valid <= 1'b1;
                    state        <= SEND;
                end

                SEND: begin
                    if (bus.tx_ready) begin
                        shift    <= shift << 8;
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            bus.tx_valid <= 1'b0;
                            state        <= IDLE;
                            busy         <= 1'b0;
                        end
                    end
                end

                default: begin
                    state        <= IDLE;
                    pipe_en      <= 1'b0;
                    halted       <= 1'b1;
                    bus.tx_valid <= 1'b0;
                    busy         <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_debug_command_unit.sv
// ---------------------------------------------------------------------------
// tb_debug_command_unit
//   Directed bench for debug_command_unit. dut0 uses the default 32-bit
//   cycle counter, dut1 a 4-bit counter for the wrap case. Expected tx bytes
//   are queued by the stimulus; monitors pop and compare on each accepted
//   byte and verify that tx_data/tx_valid hold during stalls.
// ---------------------------------------------------------------------------
module tb_debug_command_unit;

    logic clk;
    logic reset;
    logic pipe_en0, halted0, busy0;
    logic pipe_en1, halted1, busy1;

    int total;
    int passed;
    int pe0;

    logic [7:0] q0[$];
    logic [7:0] q1[$];

    logic       stall0, stall1;
    logic [7:0] hold0, hold1;

    debug_command_unit_if bif0();
    debug_command_unit_if bif1();

    // Decoder model: a recognisable pattern for 0x85, something else otherwise.
    assign bif0.result = (bif0.code == 8'h85) ? 32'hDEADBEEF : {4{bif0.code}};
    assign bif1.result = (bif1.code == 8'h85) ? 32'hDEADBEEF : {4{bif1.code}};

    debug_command_unit #(.CYCLE_W(32)) dut0 (
        .clk(clk), .reset(reset), .bus(bif0),
        .pipe_en(pipe_en0), .halted(halted0), .busy(busy0)
    );

    debug_command_unit #(.CYCLE_W(4)) dut1 (
        .clk(clk), .reset(reset), .bus(bif1),
        .pipe_en(pipe_en1), .halted(halted1), .busy(busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp)
            passed++;
        else
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    endtask

    // ---------------- monitors ----------------
    always @(negedge clk) begin
        if (pipe_en0)
            pe0++;
        if (stall0) begin
            check("tx0_hold_valid", 32'(bif0.tx_valid), 32'd1);
            check("tx0_hold_data", 32'(bif0.tx_data), 32'(hold0));
        end
        if (bif0.tx_valid && bif0.tx_ready) begin
            if (q0.size() == 0)
                check("tx0_unexpected_byte", 32'(q0.size()), 32'd1);
            else
                check("tx0_byte", 32'(bif0.tx_data), 32'(q0.pop_front()));
        end
        stall0 = reset && bif0.tx_valid && !bif0.tx_ready;
        hold0  = bif0.tx_data;
    end

    always @(negedge clk) begin
        if (stall1) begin
            check("tx1_hold_valid", 32'(bif1.tx_valid), 32'd1);
            check("tx1_hold_data", 32'(bif1.tx_data), 32'(hold1));
        end
        if (bif1.tx_valid && bif1.tx_ready) begin
            if (q1.size() == 0)
                check("tx1_unexpected_byte", 32'(q1.size()), 32'd1);
            else
                check("tx1_byte", 32'(bif1.tx_data), 32'(q1.pop_front()));
        end
        stall1 = reset && bif1.tx_valid && !bif1.tx_ready;
        hold1  = bif1.tx_data;
    end

    // ---------------- stimulus helpers ----------------
    task automatic send0(input logic [7:0] b);
        bif0.rx_data  = b;
        bif0.rx_valid = 1'b1;
        @(posedge clk);
        #1;
        bif0.rx_valid = 1'b0;
    endtask

    task automatic send1(input logic [7:0] b);
        bif1.rx_data  = b;
        bif1.rx_valid = 1'b1;
        @(posedge clk);
        #1;
        bif1.rx_valid = 1'b0;
    endtask

    task automatic push0(input logic [31:0] w);
        q0.push_back(w[31:24]); q0.push_back(w[23:16]);
        q0.push_back(w[15:8]);  q0.push_back(w[7:0]);
    endtask

    task automatic wait_idle0();
        int n;
        n = 0;
        while (busy0 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("wait_idle0", 32'(busy0), 32'd0);
    endtask

    task automatic wait_idle1();
        int n;
        n = 0;
        while (busy1 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("wait_idle1", 32'(busy1), 32'd0);
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #2 reset = 1'b0;
        #2 reset = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed sequence ----------------
    initial begin
        total = 0; passed = 0; pe0 = 0;
        stall0 = 1'b0; stall1 = 1'b0; hold0 = 8'h0; hold1 = 8'h0;
        reset = 1'b0;
        bif0.rx_data = 8'h0; bif0.rx_valid = 1'b0; bif0.tx_ready = 1'b1;
        bif1.rx_data = 8'h0; bif1.rx_valid = 1'b0; bif1.tx_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;

        // Reset asserted mid-run, outputs must drop asynchronously.
        send0(8'h02);
        repeat (3) @(posedge clk);
        #1;
        check("run_before_reset", 32'(pipe_en0), 32'd1);
        #2 reset = 1'b0;
        #1;
        check("rst_pipe_en", 32'(pipe_en0), 32'd0);
        check("rst_halted", 32'(halted0), 32'd1);
        check("rst_busy", 32'(busy0), 32'd0);
        check("rst_tx_valid", 32'(bif0.tx_valid), 32'd0);
        check("rst_tx_data", 32'(bif0.tx_data), 32'd0);
        check("rst_code", 32'(bif0.code), 32'd0);
        @(posedge clk);
        #1 reset = 1'b1;

        // Count readout after reset: four zero bytes on consecutive cycles.
        pe0 = 0;
        push0(32'h0000_0000);
        send0(8'h04);
        check("cnt_tx_valid", 32'(bif0.tx_valid), 32'd1);
        repeat (3) @(posedge clk);
        #1;
        check("cnt_busy_mid", 32'(busy0), 32'd1);
        @(posedge clk);
        #1;
        check("cnt_busy_done", 32'(busy0), 32'd0);
        check("cnt_tx_valid_done", 32'(bif0.tx_valid), 32'd0);
        check("cnt_q_empty", 32'(q0.size()), 32'd0);

        // Three single steps.
        pe0 = 0;
        for (int i = 0; i < 3; i++) begin
            send0(8'h01);
            check("step_pe_on", 32'(pipe_en0), 32'd1);
            check("step_halted", 32'(halted0), 32'd0);
            @(posedge clk);
            #1;
            check("step_pe_off", 32'(pipe_en0), 32'd0);
            check("step_busy_off", 32'(busy0), 32'd0);
        end
        check("step_pe_cycles", 32'(pe0), 32'd3);
        push0(32'h0000_0003);
        send0(8'h04);
        wait_idle0();

        // Run for 10 cycles then halt: 11 counted edges.
        pulse_reset();
        pe0 = 0;
        send0(8'h02);
        repeat (10) @(posedge clk);
        #1;
        send0(8'h03);
        check("halt_pe_off", 32'(pipe_en0), 32'd0);
        check("run_pe_cycles", 32'(pe0), 32'd11);
        push0(32'h0000_000B);
        send0(8'h04);
        wait_idle0();
        check("run_halted_after", 32'(halted0), 32'd1);

        // Decoder read, ready held high.
        push0(32'hDEAD_BEEF);
        send0(8'h85);
        check("rd_code", 32'(bif0.code), 32'h85);
        check("rd_tx_valid_early", 32'(bif0.tx_valid), 32'd0);
        @(posedge clk);
        #1;
        check("rd_tx_valid", 32'(bif0.tx_valid), 32'd1);
        check("rd_first_byte", 32'(bif0.tx_data), 32'hDE);
        wait_idle0();

        // Same read with a stalling transmitter and a RUN injected mid-send.
        pe0 = 0;
        bif0.tx_ready = 1'b0;
        push0(32'hDEAD_BEEF);
        send0(8'h85);
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            check("stall_pe_off", 32'(pipe_en0), 32'd0);
            if (!busy0 && i > 3)
                break;
            bif0.tx_ready = ~bif0.tx_ready;
            bif0.rx_data  = 8'h02;
            bif0.rx_valid = (i == 2);
        end
        bif0.rx_valid = 1'b0;
        bif0.tx_ready = 1'b1;
        check("stall_busy_done", 32'(busy0), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check("stall_run_dropped", 32'(pipe_en0), 32'd0);
        check("stall_halted", 32'(halted0), 32'd1);
        check("stall_pe_cycles", 32'(pe0), 32'd0);
        check("stall_q_empty", 32'(q0.size()), 32'd0);

        // 4-bit counter: 17 executed cycles wrap to 1.
        send1(8'h02);
        repeat (16) @(posedge clk);
        #1;
        send1(8'h03);
        check("wrap_pe_off", 32'(pipe_en1), 32'd0);
        q1.push_back(8'h00); q1.push_back(8'h00);
        q1.push_back(8'h00); q1.push_back(8'h01);
        send1(8'h04);
        wait_idle1();

        // Ignored bytes in IDLE.
        send1(8'h7F);
        check("ign7f_busy", 32'(busy1), 32'd0);
        check("ign7f_pe", 32'(pipe_en1), 32'd0);
        check("ign7f_tx_valid", 32'(bif1.tx_valid), 32'd0);
        send1(8'h03);
        check("ign03_busy", 32'(busy1), 32'd0);
        check("ign03_halted", 32'(halted1), 32'd1);
        @(posedge clk);
        #1;
        check("ign_busy_later", 32'(busy1), 32'd0);
        check("ign_tx_valid_later", 32'(bif1.tx_valid), 32'd0);
        check("q1_empty", 32'(q1.size()), 32'd0);

        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
